// File: rtl/fetch_pkg.sv
// Shared Y86-64 fetch definitions: icodes, function-code limits, lengths and the
// icode classifier. Optional iaddq support is enabled by defining FETCH_IADDQ_EN.
package fetch_pkg;

    localparam int unsigned NUM_RD_PORTS = 10;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] I_IADDQ  = 4'hC;

    localparam logic [3:0] FN_NONE       = 4'h0;
    localparam logic [3:0] FN_RRMOVQ_MAX = 4'h6;
    localparam logic [3:0] FN_OPQ_MAX    = 4'h3;
    localparam logic [3:0] FN_JXX_MAX    = 4'h6;

    localparam logic [3:0] RNONE = 4'hF;

    localparam logic [3:0] LEN_1  = 4'd1;
    localparam logic [3:0] LEN_2  = 4'd2;
    localparam logic [3:0] LEN_9  = 4'd9;
    localparam logic [3:0] LEN_10 = 4'd10;

    typedef enum logic [1:0] {
        VALC_NONE = 2'd0,
        VALC_AT1  = 2'd1,
        VALC_AT2  = 2'd2
    } valc_sel_e;

    typedef struct packed {
        logic      valid;
        logic [3:0] len;
        logic      has_reg;
        valc_sel_e valc_sel;
    } dec_t;

    // Legality and layout of one instruction from its first byte alone.
    function automatic dec_t classify(input logic [3:0] icode, input logic [3:0] ifun);
        dec_t d;
        d = '{valid: 1'b0, len: LEN_1, has_reg: 1'b0, valc_sel: VALC_NONE};
        case (icode)
            I_HALT, I_NOP, I_RET: d.valid = (ifun == FN_NONE);
            I_RRMOVQ: begin
                d.valid = (ifun <= FN_RRMOVQ_MAX); d.len = LEN_2; d.has_reg = 1'b1;
            end
            I_OPQ: begin
                d.valid = (ifun <= FN_OPQ_MAX); d.len = LEN_2; d.has_reg = 1'b1;
            end
            I_PUSHQ, I_POPQ: begin
                d.valid = (ifun == FN_NONE); d.len = LEN_2; d.has_reg = 1'b1;
            end
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
                d.valid = (ifun == FN_NONE); d.len = LEN_10; d.has_reg = 1'b1;
                d.valc_sel = VALC_AT2;
            end
`ifdef FETCH_IADDQ_EN
            I_IADDQ: begin
                d.valid = (ifun == FN_NONE); d.len = LEN_10; d.has_reg = 1'b1;
                d.valc_sel = VALC_AT2;
            end
`endif
            I_JXX: begin
                d.valid = (ifun <= FN_JXX_MAX); d.len = LEN_9; d.valc_sel = VALC_AT1;
            end
            I_CALL: begin
                d.valid = (ifun == FN_NONE); d.len = LEN_9; d.valc_sel = VALC_AT1;
            end
            default: d.valid = 1'b0;
        endcase
        if (!d.valid) begin
            d = '{valid: 1'b0, len: LEN_1, has_reg: 1'b0, valc_sel: VALC_NONE};
        end
        return d;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory read bus: one base address, ten consecutive byte lanes.
interface fetch_if;
    import fetch_pkg::*;

    logic [63:0]                   addr;
    logic [NUM_RD_PORTS-1:0][7:0]  rd_data;

    modport master (output addr, input rd_data);
    modport slave  (input addr, output rd_data);
endinterface

// File: rtl/imem.sv
// Byte instruction memory with a sequential loader and ten combinational read
// lanes at addr..addr+9; lanes past the end of memory read as zero.
module imem
    import fetch_pkg::*;
#(
    parameter int unsigned IMEM_BYTES = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_en,
    input  logic [7:0] load_data,
    fetch_if.slave     rd
);
    localparam int unsigned AW = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;

    logic [7:0]    mem [IMEM_BYTES] = '{default: 8'h00};
    logic [AW-1:0] load_ptr;
    logic [63:0]   lane_addr [NUM_RD_PORTS];

    // Reset only rewinds the pointer; memory contents survive it.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_ptr <= '0;
        end else if (load_en) begin
            mem[load_ptr] <= load_data;
            load_ptr      <= (load_ptr == AW'(IMEM_BYTES - 1)) ? '0 : load_ptr + AW'(1);
        end
    end

    always_comb begin
        for (int k = 0; k < int'(NUM_RD_PORTS); k++) begin
            lane_addr[k]  = rd.addr + 64'(k);
            rd.rd_data[k] = (lane_addr[k] < 64'(IMEM_BYTES)) ? mem[lane_addr[k][AW-1:0]] : 8'h00;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Y86-64 fetch stage: combinational decode of the instruction at PC from a
// loadable byte memory. Define FETCH_IADDQ_EN to accept iaddq (C/0).
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned IMEM_BYTES = 1024
) (
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic        instr_valid,
    output logic        imem_error,
    input  logic [63:0] PC,
    input  logic        clk,
    input  logic        rst,
    input  logic        load_en,
    input  logic [7:0]  load_data
);
    fetch_if mem_bus ();

    imem #(.IMEM_BYTES(IMEM_BYTES)) u_imem (
        .clk       (clk),
        .rst       (rst),
        .load_en   (load_en),
        .load_data (load_data),
        .rd        (mem_bus.slave)
    );

    assign mem_bus.addr = PC;

    logic        pc_in_range;
    logic [7:0]  byte0;
    dec_t        dec;
    logic [3:0]  len;
    logic [63:0] last_addr;

    // An out-of-range PC has no meaningful first byte, so it is sized as one byte.
    always_comb begin
        pc_in_range = (PC < 64'(IMEM_BYTES));
        byte0       = mem_bus.rd_data[0];
        dec         = classify(byte0[7:4], byte0[3:0]);
        len         = pc_in_range ? dec.len : LEN_1;
        last_addr   = PC + 64'(len) - 64'd1;

        icode       = byte0[7:4];
        ifun        = byte0[3:0];
        rA          = RNONE;
        rB          = RNONE;
        valC        = '0;
        valP        = PC + 64'(len);
        instr_valid = dec.valid;
        imem_error  = !pc_in_range || (last_addr >= 64'(IMEM_BYTES));

        if (imem_error) begin
            icode       = I_NOP;
            ifun        = FN_NONE;
            instr_valid = 1'b1;
        end else if (dec.valid) begin
            if (dec.has_reg) begin
                rA = mem_bus.rd_data[1][7:4];
                rB = mem_bus.rd_data[1][3:0];
            end
            case (dec.valc_sel)
                VALC_AT1: valC = mem_bus.rd_data[8:1];
                VALC_AT2: valC = mem_bus.rd_data[9:2];
                default:  valC = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed and randomized checks of fetch_stage against a byte-array model.
module tb_fetch_stage;
    localparam int unsigned MEM = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_en;
    logic [7:0]  load_data;
    logic [63:0] PC;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valP;
    logic        instr_valid, imem_error;

    fetch_stage #(.IMEM_BYTES(MEM)) dut (
        .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC), .valP(valP),
        .instr_valid(instr_valid), .imem_error(imem_error), .PC(PC),
        .clk(clk), .rst(rst), .load_en(load_en), .load_data(load_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  icode, ifun, ra, rb;
        logic [63:0] valc, valp;
        logic        valid, err;
    } exp_t;

    logic [7:0]  mref [MEM];
    int unsigned lptr;
    int          tests = 0;
    int          fails = 0;

    function automatic logic [7:0] rd(input logic [63:0] a);
        return (a < 64'(MEM)) ? mref[a[9:0]] : 8'h00;
    endfunction

    function automatic exp_t mk(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                                input logic [3:0] rb, input logic [63:0] vc, input logic [63:0] vp,
                                input logic v, input logic er);
        exp_t e;
        e = '{icode: ic, ifun: fn, ra: ra, rb: rb, valc: vc, valp: vp, valid: v, err: er};
        return e;
    endfunction

    // Reference: instruction table, length, bounds check and field extraction.
    function automatic exp_t model(input logic [63:0] pc);
        exp_t        e;
        logic [7:0]  b0;
        logic [3:0]  ic, fn;
        int          len, base;
        bit          ok;
        b0 = rd(pc); ic = b0[7:4]; fn = b0[3:0];
        ok = 1'b0; len = 1;
        case (ic)
            4'h0, 4'h1, 4'h9: begin ok = (fn == 0); len = 1; end
            4'h2:             begin ok = (fn <= 6); len = 2; end
            4'h6:             begin ok = (fn <= 3); len = 2; end
            4'hA, 4'hB:       begin ok = (fn == 0); len = 2; end
            4'h3, 4'h4, 4'h5: begin ok = (fn == 0); len = 10; end
            4'h7:             begin ok = (fn <= 6); len = 9; end
            4'h8:             begin ok = (fn == 0); len = 9; end
`ifdef FETCH_IADDQ_EN
            4'hC:             begin ok = (fn == 0); len = 10; end
`endif
            default:          ok = 1'b0;
        endcase
        if (!ok || pc >= 64'(MEM)) len = 1;
        e = '0;
        e.valp = pc + 64'(len);
        e.err  = (pc >= 64'(MEM)) || (pc + 64'(len - 1) >= 64'(MEM));
        if (e.err) begin
            e = mk(4'h1, 4'h0, 4'hF, 4'hF, 64'd0, e.valp, 1'b1, 1'b1);
        end else if (!ok) begin
            e = mk(ic, fn, 4'hF, 4'hF, 64'd0, e.valp, 1'b0, 1'b0);
        end else begin
            e.icode = ic; e.ifun = fn; e.valid = 1'b1;
            e.ra = 4'hF; e.rb = 4'hF;
            if (len >= 2 && ic != 4'h7 && ic != 4'h8) begin
                e.ra = rd(pc + 64'd1) >> 4;
                e.rb = rd(pc + 64'd1) & 8'h0F;
            end
            base = (len == 10) ? 2 : 1;
            if (len >= 9) begin
                for (int k = 7; k >= 0; k--) e.valc = (e.valc << 8) | 64'(rd(pc + 64'(base + k)));
            end
        end
        return e;
    endfunction

    task automatic do_reset();
        rst = 1'b1; load_en = 1'b1; load_data = 8'hAB;
        @(posedge clk); #1;
        rst = 1'b0; load_en = 1'b0;
        lptr = 0;
    endtask

    task automatic load_byte(input logic [7:0] b);
        load_en = 1'b1; load_data = b;
        @(posedge clk); #1;
        load_en = 1'b0;
        mref[lptr] = b;
        lptr = (lptr + 1) % MEM;
    endtask

    task automatic check(input string tag, input logic [63:0] pc, input exp_t e);
        PC = pc;
        @(negedge clk);
        tests++; assert (icode === e.icode) else begin fails++; $error("FAIL %s icode got %h exp %h", tag, icode, e.icode); end
        tests++; assert (ifun === e.ifun) else begin fails++; $error("FAIL %s ifun got %h exp %h", tag, ifun, e.ifun); end
        tests++; assert (rA === e.ra) else begin fails++; $error("FAIL %s rA got %h exp %h", tag, rA, e.ra); end
        tests++; assert (rB === e.rb) else begin fails++; $error("FAIL %s rB got %h exp %h", tag, rB, e.rb); end
        tests++; assert (valC === e.valc) else begin fails++; $error("FAIL %s valC got %h exp %h", tag, valC, e.valc); end
        tests++; assert (valP === e.valp) else begin fails++; $error("FAIL %s valP got %h exp %h", tag, valP, e.valp); end
        tests++; assert (instr_valid === e.valid) else begin fails++; $error("FAIL %s instr_valid got %b exp %b", tag, instr_valid, e.valid); end
        tests++; assert (imem_error === e.err) else begin fails++; $error("FAIL %s imem_error got %b exp %b", tag, imem_error, e.err); end
    endtask

    initial begin
        logic [7:0] b;
        for (int i = 0; i < int'(MEM); i++) mref[i] = 8'h00;
        rst = 1'b0; load_en = 1'b0; load_data = 8'h00; PC = 64'd0; lptr = 0;

        // Reset with load_en high must not write; zeroed memory decodes as halt.
        do_reset();
        check("reset_halt", 64'd0, mk(4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1, 1'b1, 1'b0));
        load_byte(8'h90);
        check("rst_load_ret", 64'd0, mk(4'h9, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1, 1'b1, 1'b0));

        do_reset();
        load_byte(8'h30); load_byte(8'hF4); load_byte(8'h0A);
        for (int i = 0; i < 7; i++) load_byte(8'h00);
        check("irmovq", 64'd0, mk(4'h3, 4'h0, 4'hF, 4'h4, 64'd10, 64'd10, 1'b1, 1'b0));

        do_reset();
        load_byte(8'h60); load_byte(8'h23); load_byte(8'h10); load_byte(8'h00);
        check("seq_opq", 64'd0, mk(4'h6, 4'h0, 4'h2, 4'h3, 64'd0, 64'd2, 1'b1, 1'b0));
        check("seq_nop", 64'd2, mk(4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd3, 1'b1, 1'b0));
        check("seq_halt", 64'd3, mk(4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd4, 1'b1, 1'b0));

        do_reset();
        load_byte(8'h27);
        check("bad_27", 64'd0, mk(4'h2, 4'h7, 4'hF, 4'hF, 64'd0, 64'd1, 1'b0, 1'b0));
        do_reset();
        load_byte(8'hD0);
        check("bad_D0", 64'd0, mk(4'hD, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1, 1'b0, 1'b0));

        do_reset();
        load_byte(8'hC0); load_byte(8'h2F); load_byte(8'h05);
        for (int i = 0; i < 7; i++) load_byte(8'h00);
`ifdef FETCH_IADDQ_EN
        check("iaddq", 64'd0, mk(4'hC, 4'h0, 4'h2, 4'hF, 64'd5, 64'd10, 1'b1, 1'b0));
`else
        check("iaddq", 64'd0, mk(4'hC, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1, 1'b0, 1'b0));
`endif

        // Fill all of memory, pinning instructions around the upper boundary.
        do_reset();
        for (int i = 0; i < int'(MEM); i++) begin
            b = {4'($urandom_range(0, 13)), 4'($urandom_range(0, 7))};
            case (i)
                1014: b = 8'h30;
                1015: b = 8'h73;
                1020: b = 8'h70;
                1022: b = 8'h20;
                1023: b = 8'h60;
                default: ;
            endcase
            load_byte(b);
        end
        check("jxx_1020", 64'd1020, mk(4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1029, 1'b1, 1'b1));
        check("pc_2000", 64'd2000, mk(4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd2001, 1'b1, 1'b1));
        check("opq_1023", 64'd1023, mk(4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1025, 1'b1, 1'b1));
        check("pc_1024", 64'd1024, mk(4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1025, 1'b1, 1'b1));
        check("pc_max", 64'hFFFF_FFFF_FFFF_FFFF, mk(4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0, 1'b1, 1'b1));
        check("irmovq_1014", 64'd1014, model(64'd1014));
        check("jxx_1015", 64'd1015, model(64'd1015));
        check("rr_1022", 64'd1022, model(64'd1022));
        for (int i = 0; i < 150; i++) begin
            logic [63:0] pc;
            pc = 64'($urandom_range(0, 1100));
            check("random", pc, model(pc));
        end

        // Loader pointer wrapped to 0 after a full pass.
        load_byte(8'h90);
        check("wrap_ret", 64'd0, mk(4'h9, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1, 1'b1, 1'b0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
